// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile
// Brief    : 32x32 register file with writeback bypass and a load-use
//            pending scoreboard that drives the decode stall.
// Revision : 1.0 - initial release
// ============================================================================
module wb_regfile #(
    parameter int BYPASS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] wb_ir,
    input  logic [31:0] wb_data,
    input  logic [31:0] id_ir,
    input  logic [31:0] ex_ir,
    input  logic        ex_valid,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic        stall
);

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam bit         c_BYPASS_EN = (BYPASS != 0);

    logic [31:0] regs_q [32];
    logic [31:0] pend_q;
    logic [31:0] pend_d;

    logic [6:0]  w_wb_op;
    logic [4:0]  w_wb_rd;
    logic        w_wb_we;
    logic [6:0]  w_ex_op;
    logic [4:0]  w_ex_rd;
    logic        w_ex_load;
    logic        w_ex_issue;
    logic [6:0]  w_id_op;

    logic [1:0][4:0]  w_src;
    logic [1:0]       w_used;
    logic [1:0]       w_byp_hit;
    logic [1:0]       w_haz;
    logic [1:0][31:0] w_rdata;
    logic             w_unused;

    assign w_wb_op = wb_ir[6:0];
    assign w_wb_rd = wb_ir[11:7];
    assign w_ex_op = ex_ir[6:0];
    assign w_ex_rd = ex_ir[11:7];
    assign w_id_op = id_ir[6:0];

    always_comb begin
        w_wb_we = 1'b0;
        case (w_wb_op)
            c_OP_LOAD, c_OP_IMM, c_OP_REG, c_OP_LUI,
            c_OP_AUIPC, c_OP_JAL, c_OP_JALR: w_wb_we = (w_wb_rd != 5'd0);
            default:                         w_wb_we = 1'b0;
        endcase
    end

    assign w_ex_load  = ex_valid && (w_ex_op == c_OP_LOAD);
    assign w_ex_issue = w_ex_load && (w_ex_rd != 5'd0) && !stall;

    // Upper-immediate and JAL forms carry no rs1; only R/store/branch carry rs2.
    assign w_used[0] = !((w_id_op == c_OP_LUI) || (w_id_op == c_OP_AUIPC) ||
                         (w_id_op == c_OP_JAL));
    assign w_used[1] = (w_id_op == c_OP_REG) || (w_id_op == c_OP_STORE) ||
                       (w_id_op == c_OP_BRANCH);
    assign w_src[0]  = id_ir[19:15];
    assign w_src[1]  = id_ir[24:20];

    generate
        for (genvar p = 0; p < 2; p++) begin : g_port
            assign w_byp_hit[p] = c_BYPASS_EN && w_wb_we && (w_wb_rd == w_src[p]);
            assign w_rdata[p]   = (w_src[p] == 5'd0) ? 32'd0 :
                                  w_byp_hit[p]       ? wb_data :
                                                       regs_q[w_src[p]];
            // A bypassed writeback resolves the pending load in the same cycle.
            assign w_haz[p]     = w_used[p] && (w_src[p] != 5'd0) &&
                                  ((pend_q[w_src[p]] && !w_byp_hit[p]) ||
                                   (w_ex_load && (w_ex_rd == w_src[p])));
        end
    endgenerate

    assign rs1_data = w_rdata[0];
    assign rs2_data = w_rdata[1];
    assign stall    = |w_haz;

    // Set is applied after clear so an issuing load wins a same-rd collision.
    always_comb begin
        pend_d = pend_q;
        if (w_wb_we) begin
            pend_d[w_wb_rd] = 1'b0;
        end
        if (w_ex_issue) begin
            pend_d[w_ex_rd] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (w_wb_we) begin
            regs_q[w_wb_rd] <= wb_data;
        end
    end

    assign w_unused = ^{wb_ir[31:12], ex_ir[31:12], id_ir[31:25], id_ir[14:7]};

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_regfile
// Brief    : Randomized and directed checks of wb_regfile (BYPASS=1 and 0)
//            against an architectural register/scoreboard model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

    localparam logic [6:0] c_LOAD   = 7'b0000011;
    localparam logic [6:0] c_IMM    = 7'b0010011;
    localparam logic [6:0] c_REG    = 7'b0110011;
    localparam logic [6:0] c_LUI    = 7'b0110111;
    localparam logic [6:0] c_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_JAL    = 7'b1101111;
    localparam logic [6:0] c_JALR   = 7'b1100111;
    localparam logic [6:0] c_STORE  = 7'b0100011;
    localparam logic [6:0] c_BRANCH = 7'b1100011;
    localparam logic [6:0] c_SYSTEM = 7'b1110011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] wb_ir, wb_data, id_ir, ex_ir;
    logic        ex_valid;
    logic [31:0] rs1_b1, rs2_b1, rs1_b0, rs2_b0;
    logic        stall_b1, stall_b0;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_pend [2];

    always #5 clk = ~clk;

    wb_regfile #(.BYPASS(1)) u_dut_byp (
        .clk(clk), .rst_n(rst_n), .wb_ir(wb_ir), .wb_data(wb_data),
        .id_ir(id_ir), .ex_ir(ex_ir), .ex_valid(ex_valid),
        .rs1_data(rs1_b1), .rs2_data(rs2_b1), .stall(stall_b1)
    );

    wb_regfile #(.BYPASS(0)) u_dut_nobyp (
        .clk(clk), .rst_n(rst_n), .wb_ir(wb_ir), .wb_data(wb_data),
        .id_ir(id_ir), .ex_ir(ex_ir), .ex_valid(ex_valid),
        .rs1_data(rs1_b0), .rs2_data(rs2_b0), .stall(stall_b0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] s1, input logic [4:0] s2);
        return {7'b0, s2, s1, 3'b010, rd, op};
    endfunction

    function automatic bit m_writes(input logic [31:0] ir);
        case (ir[6:0])
            c_LOAD, c_IMM, c_REG, c_LUI, c_AUIPC, c_JAL, c_JALR: return ir[11:7] != 5'd0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input bit byp, input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (byp && m_writes(wb_ir) && wb_ir[11:7] == idx) return wb_data;
        return m_regs[idx];
    endfunction

    function automatic bit m_hazard(input int b, input logic [4:0] s);
        bit resolved;
        if (s == 5'd0) return 1'b0;
        resolved = (b == 1) && m_writes(wb_ir) && (wb_ir[11:7] == s);
        if (m_pend[b][s] && !resolved) return 1'b1;
        return ex_valid && (ex_ir[6:0] == c_LOAD) && (ex_ir[11:7] == s);
    endfunction

    function automatic bit m_stall(input int b);
        logic [6:0] op;
        bit         use1, use2;
        op   = id_ir[6:0];
        use1 = !(op == c_LUI || op == c_AUIPC || op == c_JAL);
        use2 = (op == c_REG || op == c_STORE || op == c_BRANCH);
        return (use1 && m_hazard(b, id_ir[19:15])) || (use2 && m_hazard(b, id_ir[24:20]));
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_pend[0] = 32'd0;
        m_pend[1] = 32'd0;
    endtask

    task automatic check_outputs();
        chk("rs1_byp1",   rs1_b1,   m_read(1'b1, id_ir[19:15]));
        chk("rs2_byp1",   rs2_b1,   m_read(1'b1, id_ir[24:20]));
        chk("stall_byp1", {31'd0, stall_b1}, {31'd0, m_stall(1)});
        chk("rs1_byp0",   rs1_b0,   m_read(1'b0, id_ir[19:15]));
        chk("rs2_byp0",   rs2_b0,   m_read(1'b0, id_ir[24:20]));
        chk("stall_byp0", {31'd0, stall_b0}, {31'd0, m_stall(0)});
    endtask

    // Advance the model by one clock edge using the inputs held across it.
    task automatic commit();
        bit st [2];
        st[0] = m_stall(0);
        st[1] = m_stall(1);
        for (int b = 0; b < 2; b++) begin
            if (m_writes(wb_ir)) m_pend[b][wb_ir[11:7]] = 1'b0;
            if (ex_valid && ex_ir[6:0] == c_LOAD && ex_ir[11:7] != 5'd0 && !st[b])
                m_pend[b][ex_ir[11:7]] = 1'b1;
            m_pend[b][0] = 1'b0;
        end
        if (m_writes(wb_ir)) m_regs[wb_ir[11:7]] = wb_data;
    endtask

    task automatic step(input logic [31:0] wir, input logic [31:0] wd,
                        input logic [31:0] iir, input logic [31:0] eir, input logic ev);
        wb_ir    = wir;
        wb_data  = wd;
        id_ir    = iir;
        ex_ir    = eir;
        ex_valid = ev;
        #2;
        check_outputs();
        @(posedge clk);
        commit();
        #1;
    endtask

    function automatic logic [31:0] rand_ir(input bit load_bias);
        logic [6:0] ops [11];
        logic [6:0] op;
        logic [31:0] r;
        ops = '{c_LOAD, c_IMM, c_REG, c_LUI, c_AUIPC, c_JAL, c_JALR,
                c_STORE, c_BRANCH, c_SYSTEM, 7'b0};
        op = ops[$urandom_range(0, 10)];
        if (load_bias && $urandom_range(0, 1) == 1) op = c_LOAD;
        r  = $urandom;
        r[6:0]   = op;
        r[11:7]  = 5'($urandom_range(0, 7));
        r[19:15] = 5'($urandom_range(0, 7));
        r[24:20] = 5'($urandom_range(0, 7));
        return r;
    endfunction

    initial begin
        rst_n = 1'b0;
        wb_ir = '0; wb_data = '0; id_ir = '0; ex_ir = '0; ex_valid = 1'b0;
        m_clear();
        #3;
        id_ir = mk(c_REG, 5'd1, 5'd5, 5'd9);
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Write then read back; first edge after release performs the write.
        step(mk(c_IMM, 5'd5, 5'd0, 5'd0), 32'h1234_5678, '0, '0, 1'b0);
        step('0, '0, mk(c_IMM, 5'd1, 5'd5, 5'd0), '0, 1'b0);

        // x0 is never written; store does not write its rd field.
        step(mk(c_REG, 5'd0, 5'd1, 5'd2), 32'hFFFF_FFFF, '0, '0, 1'b0);
        step('0, '0, mk(c_REG, 5'd1, 5'd0, 5'd0), '0, 1'b0);
        step(mk(c_IMM, 5'd7, 5'd0, 5'd0), 32'h0000_0077, '0, '0, 1'b0);
        step(mk(c_STORE, 5'd7, 5'd1, 5'd2), 32'hDEAD_BEEF, '0, '0, 1'b0);
        step('0, '0, mk(c_REG, 5'd1, 5'd7, 5'd0), '0, 1'b0);

        // Same-cycle bypass vs stored value.
        step(mk(c_IMM, 5'd9, 5'd0, 5'd0), 32'h0000_0011, '0, '0, 1'b0);
        step(mk(c_IMM, 5'd9, 5'd0, 5'd0), 32'hAA55_AA55, mk(c_REG, 5'd1, 5'd0, 5'd9), '0, 1'b0);

        // Load-use stall, held by the scoreboard, released by writeback.
        step('0, '0, mk(c_REG, 5'd1, 5'd3, 5'd0), mk(c_LOAD, 5'd3, 5'd1, 5'd0), 1'b1);
        step('0, '0, mk(c_REG, 5'd1, 5'd3, 5'd0), '0, 1'b0);
        step(mk(c_LOAD, 5'd3, 5'd1, 5'd0), 32'h0000_0042, mk(c_REG, 5'd1, 5'd3, 5'd0), '0, 1'b0);
        step('0, '0, mk(c_REG, 5'd1, 5'd3, 5'd0), '0, 1'b0);

        // Set/clear collision on x4.
        step(mk(c_IMM, 5'd4, 5'd0, 5'd0), 32'h0000_0005, '0, mk(c_LOAD, 5'd4, 5'd1, 5'd0), 1'b1);
        step('0, '0, mk(c_REG, 5'd1, 5'd4, 5'd0), '0, 1'b0);
        step(mk(c_LOAD, 5'd4, 5'd1, 5'd0), 32'h0000_0099, mk(c_REG, 5'd1, 5'd4, 5'd0), '0, 1'b0);
        step('0, '0, mk(c_REG, 5'd1, 5'd4, 5'd0), '0, 1'b0);

        // Asynchronous reset with a load outstanding on x6.
        step(mk(c_IMM, 5'd6, 5'd0, 5'd0), 32'h0000_0010, '0, '0, 1'b0);
        step('0, '0, '0, mk(c_LOAD, 5'd6, 5'd1, 5'd0), 1'b1);
        wb_ir = '0; wb_data = '0; ex_ir = '0; ex_valid = 1'b0;
        id_ir = mk(c_REG, 5'd1, 5'd6, 5'd6);
        #1;
        check_outputs();
        rst_n = 1'b0;
        m_clear();
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        step('0, '0, mk(c_REG, 5'd1, 5'd6, 5'd6), '0, 1'b0);

        for (int i = 0; i < 600; i++) begin
            step(rand_ir(1'b0), $urandom, rand_ir(1'b0), rand_ir(1'b1),
                 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter BYPASS, default 1, meaning: 1 enables the write-through bypass from the writeback port to the read ports; 0 disables it.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port wb_ir  input  32  instruction in the writeback stage.
REQ-005 SHALL have port wb_data  input  32  selected writeback value (ALU result, load data or LUI immediate).
REQ-006 SHALL have port id_ir  input  32  instruction in decode; rs1=[19:15], rs2=[24:20].
REQ-007 SHALL have port ex_ir  input  32  instruction in execute.
REQ-008 SHALL have port ex_valid  input  1  ex_ir holds a live instruction.
REQ-009 SHALL have port rs1_data  output  32  read data for rs1.
REQ-010 SHALL have port rs2_data  output  32  read data for rs2.
REQ-011 SHALL have port stall  output  1  decode must hold; a source depends on an outstanding load.

Function
REQ-012 SHALL hold 32 x 32-bit registers; x0 reads 0 always and is never written.
REQ-013 SHALL write wb_data to regs[wb_ir[11:7]] at the clock edge when wb_ir[6:0] is one of 0000011, 0010011, 0110011, 0110111, 0010111, 1101111, 1100111 and rd != 0 (the write condition, "wb_we").
REQ-014 SHALL not write for any other opcode (store 0100011, branch 1100011, system, all-zero bubble).
REQ-015 SHALL drive read ports combinationally: 0 when the index is 0; else wb_data when BYPASS=1, wb_we is set and wb rd equals the index; else the stored register value.
REQ-016 SHALL keep a 32-bit pending scoreboard pend[31:0]; pend[0] is constantly 0.
REQ-017 SHALL set pend[rd] at the clock edge when ex_valid=1, ex_ir[6:0]=0000011, rd=ex_ir[11:7]!=0 and stall=0.
REQ-018 SHALL clear pend[rd] at the clock edge when wb_we is set for that rd.
REQ-019 SHALL let set win over clear when both target the same register in the same cycle.
REQ-020 SHALL consider rs1 used unless the id opcode is 0110111, 0010111 or 1101111, and rs2 used only for opcodes 0110011, 0100011 and 1100011.
REQ-021 SHALL assert stall combinationally when a used source index s!=0 satisfies either: (a) pend[s]=1 and not (wb_we with wb rd=s and BYPASS=1); or (b) ex_valid=1, ex_ir is a load and ex rd=s.
REQ-022 SHALL not let stall gate writes; writeback proceeds regardless of stall.
REQ-023 SHALL compute no arithmetic; all data paths are 32-bit passthrough.

Reset
REQ-024 SHALL, while rst_n=0, asynchronously clear all registers and pend to 0; rs1_data=rs2_data=0 and stall=0 then follow from REQ-015/021 with zeroed state.
REQ-025 SHALL discard a pending load in flight when reset is asserted mid-operation; after release, no stall results from it.
REQ-026 SHALL perform the first write at the first rising edge after rst_n deasserts.

Verification
REQ-027 Write/read: wb_ir=ADDI x5 (0010011, rd=5), wb_data=0x1234_5678 for 1 cycle; then id_ir reads rs1=5 -> rs1_data=0x1234_5678.
REQ-028 x0: wb_ir=ADD rd=0, wb_data=0xFFFF_FFFF; then id reads rs1=0,rs2=0 -> both 0; a store in wb with wb_ir[11:7]=7 -> x7 unchanged.
REQ-029 Bypass: in the same cycle, wb writes x9=0xAA55_AA55 and id reads rs2=9 (R-type) -> rs2_data=0xAA55_AA55 with BYPASS=1, old value with BYPASS=0.
REQ-030 Load-use: ex holds LW x3, id holds ADD rs1=3 -> stall=1; after the edge pend[3]=1 and stall stays 1; when wb writes x3=0x42, stall=0 in that cycle (BYPASS=1) and rs1_data=0x42.
REQ-031 Set/clear collision: wb writes x4 while ex LW x4 issues -> pend[4]=1 after the edge; a later id read of x4 stalls until the second writeback.
REQ-032 Reset mid-op: pend[6]=1 and x6=0x10; assert rst_n=0 asynchronously -> x6=0, stall=0 immediately; after release, id reading x6 gives 0 with no stall.
